serial_transmitter: RTL

Bit-serial frame transmitter, clocked by `flip_clk`, that drives the two-wire `sda`/`sclk` link consumed by `serial_receiver`. It is the sending end of the same protocol. On a start request it captures a parallel word and shifts it out MSB first. The receiver samples `sda` on each falling `sclk` edge. After the last falling edge, the receiver's shift register holds the word exactly as presented here. It sits in the stimulus/host-emulation FPGA, or in loopback benches, ahead of the SCA unlock DUT controller.

---
 rtl/serial_transmitter_if.sv | 30 +++
 rtl/serial_transmitter.sv | 136 +++++++++++++
 2 files changed

// File: rtl/serial_transmitter_if.sv
// Handshake and serial-link bundle for serial_transmitter.
// The host side drives start/data_in and watches status and link lines.
interface serial_transmitter_if #(
    parameter int unsigned DATA_LEN = 24
);
    logic                start;
    logic [DATA_LEN-1:0] data_in;
    logic                busy;
    logic                done;
    logic                sda;
    logic                sclk;

    modport master (
        output start,
        output data_in,
        input  busy,
        input  done,
        input  sda,
        input  sclk
    );

    modport slave (
        input  start,
        input  data_in,
        output busy,
        output done,
        output sda,
        output sclk
    );
endinterface

// File: rtl/serial_transmitter.sv
// Bit-serial frame transmitter: shifts a captured word out MSB first on sda/sclk.
// Each bit spends HALF_DIV cycles in each of SETUP (sclk low), HIGH and HOLD (sclk low).
module serial_transmitter #(
    parameter int unsigned DATA_LEN = 24,
    parameter int unsigned HALF_DIV = 2
) (
    input  logic                 flip_clk,
    input  logic                 reset,
    serial_transmitter_if.slave  bus
);
    localparam int unsigned PHASE_W = $clog2(HALF_DIV + 1);
    localparam int unsigned BIT_W   = $clog2(DATA_LEN + 1);

    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(HALF_DIV - 1);
    localparam logic [PHASE_W-1:0] PHASE_ONE  = PHASE_W'(1);
    localparam logic [BIT_W-1:0]   BIT_FIRST  = BIT_W'(DATA_LEN - 1);
    localparam logic [BIT_W-1:0]   BIT_ONE    = BIT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_HIGH,
        ST_HOLD
    } state_e;

    state_e              state_q, state_d;
    logic [DATA_LEN-1:0] shift_q, shift_d;
    logic [PHASE_W-1:0]  phase_q, phase_d;
    logic [BIT_W-1:0]    bit_q,   bit_d;
    logic                sda_q,   sda_d;
    logic                sclk_q,  sclk_d;
    logic                busy_q,  busy_d;
    logic                done_q,  done_d;

    logic phase_last;

    always_ff @(posedge flip_clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            phase_q <= '0;
            bit_q   <= '0;
            sda_q   <= 1'b0;
            sclk_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            sda_q   <= sda_d;
            sclk_q  <= sclk_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign phase_last = (phase_q == PHASE_LAST);

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        sda_d   = sda_q;
        sclk_d  = sclk_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                sda_d  = 1'b0;
                sclk_d = 1'b0;
                busy_d = 1'b0;
                if (bus.start) begin
                    shift_d = bus.data_in;
                    sda_d   = bus.data_in[DATA_LEN-1];
                    bit_d   = BIT_FIRST;
                    phase_d = '0;
                    busy_d  = 1'b1;
                    state_d = ST_SETUP;
                end
            end

            ST_SETUP: begin
                if (phase_last) begin
                    phase_d = '0;
                    sclk_d  = 1'b1;
                    state_d = ST_HIGH;
                end else begin
                    phase_d = phase_q + PHASE_ONE;
                end
            end

            ST_HIGH: begin
                if (phase_last) begin
                    phase_d = '0;
                    sclk_d  = 1'b0;
                    state_d = ST_HOLD;
                end else begin
                    phase_d = phase_q + PHASE_ONE;
                end
            end

            ST_HOLD: begin
                if (phase_last) begin
                    phase_d = '0;
                    if (bit_q != '0) begin
                        // Next MSB is taken from the shifted value so DATA_LEN=1 needs no special case.
                        shift_d = shift_q << 1;
                        sda_d   = shift_d[DATA_LEN-1];
                        bit_d   = bit_q - BIT_ONE;
                        state_d = ST_SETUP;
                    end else begin
                        sda_d   = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else begin
                    phase_d = phase_q + PHASE_ONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sda  = sda_q;
    assign bus.sclk = sclk_q;
endmodule
